// File: rtl/bnn_infer_seq.sv
// bnn_infer_seq: pixel stream assembler and N-layer BNN engine sequencer.
// Optional watchdog/ERR state: define BNN_INFER_SEQ_TIMEOUT_EN.
module bnn_infer_seq #(
   parameter int NUM_PIXELS = 784,
   parameter int LANES      = 1,
   parameter int NUM_LAYERS = 3,
   parameter int ANS_W      = 4,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic                  pix_valid,
   input  logic [LANES-1:0]      pix_data,
   output logic                  pix_ready,
   output logic [NUM_PIXELS-1:0] pixels,
   output logic [NUM_LAYERS-1:0] layer_start,
   input  logic [NUM_LAYERS-1:0] layer_done,
   input  logic [ANS_W-1:0]      answer_in,
   output logic [ANS_W-1:0]      answer,
   output logic                  answer_valid,
   output logic                  busy,
   output logic [2:0]            state,
   output logic                  error
);

   localparam int BEATS = NUM_PIXELS / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LAYERS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [NUM_PIXELS-1:0] pixels_q, pixels_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ANS_W-1:0]      answer_q, answer_d;
   logic                  ans_vld_q, ans_vld_d;
   logic                  pend_q, pend_d;

   logic beat_acc;
   logic last_beat;
   logic done_hit;
   logic last_layer;
   logic wdog_exp;

   assign beat_acc   = (state_q == S_LOAD) && mode && pix_valid;
   assign last_beat  = (cnt_q == LAST_BEAT);
   assign done_hit   = (state_q == S_RUN) && layer_done[idx_q];
   assign last_layer = (idx_q == LAST_IDX);

`ifdef BNN_INFER_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

   // Cleared while a start pulse is out, so a stale count never expires.
   always_comb begin
      wdog_d = wdog_q;
      if (state_q == S_RUN) begin
         wdog_d = pend_q ? '0 : wdog_q + 1'b1;
      end
   end

   assign wdog_exp = (state_q == S_RUN) && !pend_q && (&wdog_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   logic [TIMEOUT_W-1:0] unused_wdog;
   assign unused_wdog = '0;
   assign wdog_exp    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (mode) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (!mode) begin
               state_d = S_IDLE;
            end else if (beat_acc && last_beat) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (done_hit) begin
               if (last_layer) state_d = S_DONE;
            end else if (wdog_exp) begin
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            if (!mode) state_d = S_IDLE;
         end
         S_ERR: begin
            if (!mode) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pixels_d  = pixels_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      answer_d  = answer_q;
      ans_vld_d = ans_vld_q;
      pend_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (mode) begin
               cnt_d     = '0;
               ans_vld_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (!mode) begin
               cnt_d = '0;
            end else if (beat_acc) begin
               pixels_d[cnt_q*LANES +: LANES] = pix_data;
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  cnt_d  = '0;
                  idx_d  = '0;
                  pend_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (done_hit) begin
               if (last_layer) begin
                  answer_d  = answer_in;
                  ans_vld_d = 1'b1;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  pend_d = 1'b1;
               end
            end else if (wdog_exp) begin
               ans_vld_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixels_q  <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         answer_q  <= '0;
         ans_vld_q <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         pixels_q  <= pixels_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         answer_q  <= answer_d;
         ans_vld_q <= ans_vld_d;
         pend_q    <= pend_d;
      end
   end

   always_comb begin
      pix_ready   = (state_q == S_LOAD);
      busy        = (state_q == S_LOAD) || (state_q == S_RUN);
      layer_start = '0;
      if ((state_q == S_RUN) && pend_q) begin
         layer_start[idx_q] = 1'b1;
      end
`ifdef BNN_INFER_SEQ_TIMEOUT_EN
      error = (state_q == S_ERR);
`else
      error = 1'b0;
`endif
   end

   assign state        = state_q;
   assign pixels       = pixels_q;
   assign answer       = answer_q;
   assign answer_valid = ans_vld_q;

endmodule
